rsqrt_seed: RTL
===============

Name: rsqrt_seed

Overview:
- Pipelined initial-estimate generator for inverse square root.
- Takes a signed fixed-point operand S and produces y0 ≈ 1/sqrt(S), using leading-one detection, a parity-split reciprocal-sqrt LUT and an exponent-halving shift.
- Sits directly upstream of the Goldschmidt rsqrt/sqrt refinement pipeline.
- Its outputs s_out, est and valid drive that stage's in, est and start, cycle-aligned.

Parameters:
- IW, 16: integer bits of the sfp format, sign included.
- QW, 16: fractional bits. Total width W = IW+QW.
- LUT_BITS, 6: mantissa fraction bits used to index the LUT. Table depth is 2*2^LUT_BITS.

Ports:
- clk, input, 1: clock, rising edge.
- resetn, input, 1: asynchronous active-low reset.
- start, input, 1: operand strobe. One operand is accepted per cycle when high.
- in, sfp_if.in, W: operand S, two's complement Q(IW.QW).
- s_out, sfp_if.out, W: S delayed to align with est.
- est, sfp_if.out, W: seed y0, non-negative Q(IW.QW).
- valid, output, 1: est/s_out valid. Intended to feed the downstream start.
- zero, output, 1: S == 0 for the current valid result.
- neg, output, 1: S < 0 for the current valid result.

Behaviour:
- One clock (clk); reset is asynchronous, active-low (resetn).
- Reset clears the valid shift register and all output registers: valid=0, est=0, s_out=0, zero=0, neg=0. Data registers for stages 0-1 also clear.
- Latency is 3 cycles, throughput 1/cycle. valid at cycle t+3 mirrors start at t.
- No backpressure. The downstream stage accepts every valid pulse.
- Pipeline registers load only when their stage's valid bit is set. Otherwise they hold.
- Stage 0 (register on start):
  - S, neg = S[W-1], zero = (S==0).
  - p = index of the most-significant 1 in S (0..W-2), computed by priority encoder. Unused when neg or zero.
- Stage 1:
  - Exponent e = p - QW, signed, range [-QW, IW-2].
  - Odd-exponent correction: if e is odd, use e' = e-1 and parity bit par = 1; else e' = e, par = 0.
  - LUT index = {par, LUT_BITS bits of S immediately below bit p}. Missing low bits when p < LUT_BITS are zero-filled.
  - Register r = LUT[index] and h = e'/2 (arithmetic shift).
- LUT contents:
  - Entry(par, k) = 1/sqrt((1+par)*(1+(k+0.5)/2^LUT_BITS)), rounded to nearest.
  - Entries are stored UQ1.QW, value in (0.5, 1].
  - The LUT is a constant ROM with no reset.
- Stage 2 (output register):
  - est = r >> h when h ≥ 0, r << (-h) when h < 0, with the result aligned to Q(IW.QW).
  - Left-shift overflow past bit W-2 saturates est to the maximum positive value 0x7FFF_FFFF (for the default W=32).
  - Right shift truncates. An underflow result of 0 is forced to 1 LSB.
  - zero: est = max positive.
  - neg: est = 0.
  - s_out = S. The zero/neg flags propagate with the data.
- Accuracy: relative error |est·sqrt(S) − 1| ≤ 2^-(LUT_BITS+1) for positive S where no saturation or underflow occurs.
- Simultaneous events:
  - start while the pipe is full: new operand enters stage 0 while the others advance.
  - Same operand value repeated: independent results.
- Reset mid-operation: all in-flight results are dropped, and valid stays 0 until 3 cycles after the next start.

Decomposition:
- Package rsqrt_seed_pkg holds:
  - the LUT_BITS default and W helper;
  - a constant function gen_rsqrt_lut(QW, LUT_BITS) returning the ROM array (real math, elaboration only);
  - the saturation constant SFP_MAX(W).
- One sub-module: lzc_pri (W-bit leading-one priority encoder → index plus none flag). Reusable by later normalize blocks.

Test Plan:
- S=4.0 (0x0004_0000), single start → valid exactly 3 cycles later, est within 2^-7 relative of 0.5 (0x0000_8000), s_out=0x0004_0000, zero=neg=0.
- S=2.0 and S=0.25 (odd/even exponent, e<0) → est ≈ 0.70711 and ≈ 2.0 within tolerance. par=1 path is exercised for 2.0.
- S=0 → est=0x7FFF_FFFF, zero=1. S=-1.0 (0xFFFF_0000) → est=0, neg=1. S=1 LSB (2^-16) → est ≈ 256.0, no saturation.
- 100 back-to-back random positive S values with start held high → 100 consecutive valid pulses, in order, each meeting the accuracy bound. Also feed results through Goldschmidt and check rsqrt error ≤ 2^-12.
- Pulse resetn low while 2 operands are in flight → valid, est, s_out, zero and neg are 0 immediately. No stale valid after release. The next start yields valid at +3.

Source files
------------

// File: rtl/rsqrt_seed_pkg.sv
// Shared constants and elaboration-time helpers for the rsqrt seed pipeline:
// format width, saturation value and the reciprocal-sqrt ROM generator.
package rsqrt_seed_pkg;

    localparam int unsigned LUT_BITS_DEF = 6;

    function automatic int unsigned sfp_w(input int unsigned iw, input int unsigned qw);
        return iw + qw;
    endfunction

    function automatic logic [63:0] sfp_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Entry(par,k) = round(2^qw / sqrt((1+par)*(1+(k+0.5)/2^lut_bits))), found as an
    // exact integer square root of 2^(2qw+lut_bits+1)/d, then rounded to nearest.
    function automatic longint unsigned gen_rsqrt_lut(input int unsigned qw,
                                                      input int unsigned lut_bits,
                                                      input int unsigned idx);
        longint unsigned par;
        longint unsigned k;
        longint unsigned d;
        longint unsigned tgt;
        longint unsigned y;
        longint unsigned t;
        par = 64'((idx >> lut_bits) & 32'd1);
        k   = 64'(idx & ((32'd1 << lut_bits) - 32'd1));
        d   = (64'd1 + par) * ((64'd2 << lut_bits) + 64'd2 * k + 64'd1);
        tgt = 64'd1 << (2 * qw + lut_bits + 1);
        y   = 64'd0;
        for (int unsigned b = qw + 1; b > 0; b--) begin
            t = y | (64'd1 << (b - 1));
            if (t * t * d <= tgt) y = t;
        end
        if ((64'd2 * y + 64'd1) * (64'd2 * y + 64'd1) * d <= 64'd4 * tgt) y = y + 64'd1;
        return y;
    endfunction

endpackage

// File: rtl/lzc_pri.sv
// Leading-one priority encoder: index of the most-significant set bit of vec_i,
// with none_o flagging an all-zero input.
module lzc_pri #(
    parameter int unsigned W = 32,
    localparam int unsigned PW = $clog2(W)
) (
    input  logic [W-1:0]  vec_i,
    output logic [PW-1:0] idx_o,
    output logic          none_o
);

    always_comb begin
        idx_o  = '0;
        none_o = 1'b1;
        for (int unsigned i = 0; i < W; i++) begin
            if (vec_i[i]) begin
                idx_o  = PW'(i);
                none_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/rsqrt_seed.sv
// Three-stage inverse-square-root seed generator: leading-one detect, parity-split
// LUT lookup, exponent-halving shift with saturation/underflow handling.
module rsqrt_seed
    import rsqrt_seed_pkg::*;
#(
    parameter int unsigned IW       = 16,
    parameter int unsigned QW       = 16,
    parameter int unsigned LUT_BITS = LUT_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [IW+QW-1:0]      in,
    output logic [IW+QW-1:0]      s_out,
    output logic [IW+QW-1:0]      est,
    output logic                  valid,
    output logic                  zero,
    output logic                  neg
);

    localparam int unsigned W     = sfp_w(IW, QW);
    localparam int unsigned PW    = $clog2(W);
    localparam int unsigned EW    = PW + 2;
    localparam int unsigned LW    = QW + 1;
    localparam int unsigned IXW   = LUT_BITS + 1;
    localparam int unsigned DEPTH = 2 * (2 ** LUT_BITS);
    localparam logic [W-1:0] EST_MAX = W'(sfp_max(W));

    logic [LW-1:0] lut_rom [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        localparam logic [LW-1:0] ENTRY = LW'(gen_rsqrt_lut(QW, LUT_BITS, i));
        assign lut_rom[i] = ENTRY;
    end

    // Stage 0
    logic [PW-1:0] p_lzc;
    logic          none_lzc;
    logic          v0_q, neg0_q, zero0_q;
    logic [W-1:0]  s0_q;
    logic [PW-1:0] p0_q;

    lzc_pri #(.W(W)) u_lzc (
        .vec_i  (in),
        .idx_o  (p_lzc),
        .none_o (none_lzc)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v0_q    <= 1'b0;
            s0_q    <= '0;
            neg0_q  <= 1'b0;
            zero0_q <= 1'b0;
            p0_q    <= '0;
        end else begin
            v0_q <= start;
            if (start) begin
                s0_q    <= in;
                neg0_q  <= in[W-1];
                zero0_q <= none_lzc;
                p0_q    <= p_lzc;
            end
        end
    end

    // Stage 1
    logic signed [EW-1:0] e_s, ep_s, h_d;
    logic                 par_d;
    logic [LUT_BITS-1:0]  frac_d;
    logic [IXW-1:0]       idx_d;
    logic [LW-1:0]        r_d;

    always_comb begin
        e_s   = signed'(EW'(p0_q)) - signed'(EW'(QW));
        par_d = e_s[0];
        ep_s  = e_s - signed'(EW'(par_d));
        h_d   = ep_s >>> 1;
        // Appending LUT_BITS zeros before shifting zero-fills the index when p < LUT_BITS.
        frac_d = LUT_BITS'({s0_q, {LUT_BITS{1'b0}}} >> p0_q);
        idx_d  = {par_d, frac_d};
        r_d    = lut_rom[idx_d];
    end

    logic                 v1_q, neg1_q, zero1_q;
    logic [W-1:0]         s1_q;
    logic [LW-1:0]        r1_q;
    logic signed [EW-1:0] h1_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            v1_q    <= 1'b0;
            s1_q    <= '0;
            neg1_q  <= 1'b0;
            zero1_q <= 1'b0;
            r1_q    <= '0;
            h1_q    <= '0;
        end else begin
            v1_q <= v0_q;
            if (v0_q) begin
                s1_q    <= s0_q;
                neg1_q  <= neg0_q;
                zero1_q <= zero0_q;
                r1_q    <= r_d;
                h1_q    <= h_d;
            end
        end
    end

    // Stage 2
    logic [EW-1:0]  hmag;
    logic [2*W-1:0] wide_l;
    logic [W-1:0]   right_v, shift_v, est_d;

    always_comb begin
        hmag    = h1_q[EW-1] ? $unsigned(-h1_q) : $unsigned(h1_q);
        wide_l  = {{(2*W-LW){1'b0}}, r1_q} << hmag;
        right_v = W'(r1_q) >> hmag;
        if (h1_q[EW-1]) begin
            shift_v = (|wide_l[2*W-1:W-1]) ? EST_MAX : wide_l[W-1:0];
        end else begin
            shift_v = (right_v == '0) ? W'(1) : right_v;
        end
        est_d = shift_v;
        if (zero1_q)     est_d = EST_MAX;
        else if (neg1_q) est_d = '0;
    end

    logic          valid_q, zero_q, neg_q;
    logic [W-1:0]  est_q, s_out_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            est_q   <= '0;
            s_out_q <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            valid_q <= v1_q;
            if (v1_q) begin
                est_q   <= est_d;
                s_out_q <= s1_q;
                zero_q  <= zero1_q;
                neg_q   <= neg1_q;
            end
        end
    end

    assign valid = valid_q;
    assign est   = est_q;
    assign s_out = s_out_q;
    assign zero  = zero_q;
    assign neg   = neg_q;

endmodule
